// File: rtl/water_level_ctrl.sv
// Water-level sequencer: filters six raw probes into a stable 0-6 level with
// falling-edge hysteresis and runs the alarm/ack/test/fault display state machine.
module water_level_ctrl #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES   = 4000,
  parameter int unsigned TEST_CYCLES   = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] probe,
  input  logic       ack_pulse,
  input  logic       test_pulse,
  output logic [2:0] state,
  output logic [2:0] level,
  output logic       mute,
  output logic       fault
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES);
  localparam int unsigned TW = $clog2(TEST_CYCLES);
  localparam logic [CW-1:0] CNT_STABLE = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HOLD   = CW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LOAD   = TW'(TEST_CYCLES - 1);

  typedef enum logic [1:0] {NORMAL, MUTED, TEST, FAULT} fsm_t;

  logic [5:0]    p_meta, p_sync, cand;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic [2:0]    cand_lvl, level_nxt, ack_lvl, state_d;
  logic          cand_ok, fault_nxt, tmr_load, ack_take, fmute, fmute_set, mute_d;
  fsm_t          fsm, fsm_nxt;

  // Two-flop synchronizer for the asynchronous probe switches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_meta <= '0;
      p_sync <= '0;
    end else begin
      p_meta <= probe;
      p_sync <= p_meta;
    end
  end

  // Thermometer decode of the candidate pattern
  always_comb begin
    cand_ok  = 1'b1;
    cand_lvl = 3'd0;
    case (cand)
      6'b000000: cand_lvl = 3'd0;
      6'b000001: cand_lvl = 3'd1;
      6'b000011: cand_lvl = 3'd2;
      6'b000111: cand_lvl = 3'd3;
      6'b001111: cand_lvl = 3'd4;
      6'b011111: cand_lvl = 3'd5;
      6'b111111: cand_lvl = 3'd6;
      default:   cand_ok  = 1'b0;
    endcase
  end

  // Acceptance rules: fast rise, slow fall, fault freezes level until a valid pattern settles
  always_comb begin
    level_nxt = level;
    fault_nxt = fault;
    if (!cand_ok) begin
      if (cnt == CNT_STABLE) fault_nxt = 1'b1;
    end else if (fault) begin
      if (cnt == CNT_STABLE) begin
        fault_nxt = 1'b0;
        level_nxt = cand_lvl;
      end
    end else if (cand_lvl > level && cnt == CNT_STABLE) begin
      level_nxt = cand_lvl;
    end else if (cand_lvl < level && cnt == CNT_HOLD) begin
      level_nxt = cand_lvl;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand  <= '0;
      cnt   <= '0;
      level <= '0;
      fault <= 1'b0;
    end else begin
      if (p_sync != cand) begin
        cand <= p_sync;
        cnt  <= '0;
      end else if (cnt != CNT_HOLD) begin
        cnt <= cnt + CW'(1);
      end
      level <= level_nxt;
      fault <= fault_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm <= NORMAL;
    else      fsm <= fsm_nxt;
  end

  // Transitions react to the level/fault being committed on this same edge
  always_comb begin
    fsm_nxt   = fsm;
    tmr_load  = 1'b0;
    ack_take  = 1'b0;
    fmute_set = 1'b0;
    if (fault_nxt && fsm != FAULT) begin
      fsm_nxt = FAULT;
    end else begin
      case (fsm)
        NORMAL: begin
          if (level_nxt == level) begin
            if (ack_pulse && level != 3'd0) begin
              fsm_nxt  = MUTED;
              ack_take = 1'b1;
            end else if (test_pulse && level == 3'd0) begin
              fsm_nxt  = TEST;
              tmr_load = 1'b1;
            end
          end
        end
        MUTED: begin
          if (level_nxt > ack_lvl || level_nxt == 3'd0) fsm_nxt = NORMAL;
        end
        TEST: begin
          if (tmr == '0 || ack_pulse || level_nxt != 3'd0) fsm_nxt = NORMAL;
          else if (test_pulse)                              tmr_load = 1'b1;
        end
        FAULT: begin
          if (!fault_nxt)     fsm_nxt = NORMAL;
          else if (ack_pulse) fmute_set = 1'b1;
        end
        default: fsm_nxt = NORMAL;
      endcase
    end
  end

  always_comb begin
    state_d = level;
    mute_d  = 1'b0;
    case (fsm)
      NORMAL: state_d = level;
      MUTED: begin
        state_d = level;
        mute_d  = 1'b1;
      end
      TEST:  state_d = 3'd7;
      FAULT: begin
        state_d = 3'd6;
        mute_d  = fmute;
      end
      default: state_d = level;
    endcase
  end

  // Test timer, ack snapshot, fault silence flag and registered display outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr     <= '0;
      ack_lvl <= '0;
      fmute   <= 1'b0;
      state   <= '0;
      mute    <= 1'b0;
    end else begin
      if (tmr_load)                       tmr <= TMR_LOAD;
      else if (fsm == TEST && tmr != '0)  tmr <= tmr - TW'(1);
      if (ack_take) ack_lvl <= level;
      fmute <= (fsm == FAULT && fsm_nxt == FAULT) && (fmute || fmute_set);
      state <= state_d;
      mute  <= mute_d;
    end
  end

endmodule

// File: tb/tb_water_level_ctrl.sv
// Directed bench for water_level_ctrl: timestamp-based behavioural model checked
// every cycle, plus hand-computed literal checks of the key latencies.
module tb_water_level_ctrl;

  localparam int unsigned S = 4;
  localparam int unsigned H = 16;
  localparam int unsigned T = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] probe = '0;
  logic       ack_pulse = 1'b0;
  logic       test_pulse = 1'b0;
  logic [2:0] state, level;
  logic       mute, fault;

  int checks = 0;
  int errors = 0;

  water_level_ctrl #(.STABLE_CYCLES(S), .HOLD_CYCLES(H), .TEST_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .probe(probe), .ack_pulse(ack_pulse),
    .test_pulse(test_pulse), .state(state), .level(level), .mute(mute), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Level of a thermometer pattern, or -1 when the pattern is not a thermometer code
  function automatic int therm_level(input logic [5:0] p);
    int ones;
    ones = $countones(p);
    if (p == 6'((1 << ones) - 1)) return ones;
    return -1;
  endfunction

  localparam int M_NORMAL = 0, M_MUTED = 1, M_TEST = 2, M_FAULT = 3;

  logic [5:0] hist[$] = '{6'd0, 6'd0, 6'd0};
  int age = 1;
  int edge_n = 0;
  int m_level = 0, m_fault = 0, m_mode = M_NORMAL, m_ack_lvl = 0;
  int m_tstart = 0, m_fmute = 0, e_state = 0, e_mute = 0;

  // hist[0] is the sample that is the filter candidate this edge; age is how long it has held
  initial forever begin : model
    int v, nl, nf;
    @(posedge clk or negedge rst);
    if (!rst) begin
      hist = '{6'd0, 6'd0, 6'd0};
      age = 1; edge_n = 0;
      m_level = 0; m_fault = 0; m_mode = M_NORMAL; m_ack_lvl = 0;
      m_tstart = 0; m_fmute = 0; e_state = 0; e_mute = 0;
    end else begin
      edge_n++;
      v  = therm_level(hist[0]);
      nl = m_level;
      nf = m_fault;
      if (v < 0) begin
        if (age == S) nf = 1;
      end else if (m_fault != 0) begin
        if (age == S) begin nf = 0; nl = v; end
      end else if (v > m_level && age == S) begin
        nl = v;
      end else if (v < m_level && age >= H) begin
        nl = v;
      end
      case (m_mode)
        M_MUTED: begin e_state = m_level; e_mute = 1; end
        M_TEST:  begin e_state = 7;       e_mute = 0; end
        M_FAULT: begin e_state = 6;       e_mute = m_fmute; end
        default: begin e_state = m_level; e_mute = 0; end
      endcase
      if (nf != 0 && m_mode != M_FAULT) begin
        m_mode = M_FAULT; m_fmute = 0;
      end else begin
        case (m_mode)
          M_NORMAL:
            if (nl == m_level) begin
              if (ack_pulse && m_level >= 1) begin m_mode = M_MUTED; m_ack_lvl = m_level; end
              else if (test_pulse && m_level == 0) begin m_mode = M_TEST; m_tstart = edge_n; end
            end
          M_MUTED: if (nl > m_ack_lvl || nl == 0) m_mode = M_NORMAL;
          M_TEST:
            if (edge_n - m_tstart >= T || ack_pulse || nl != 0) m_mode = M_NORMAL;
            else if (test_pulse) m_tstart = edge_n;
          default:
            if (nf == 0) begin m_mode = M_NORMAL; m_fmute = 0; end
            else if (ack_pulse) m_fmute = 1;
        endcase
      end
      m_level = nl;
      m_fault = nf;
      age = (hist[1] == hist[0]) ? age + 1 : 1;
      void'(hist.pop_front());
      hist.push_back(probe);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("model_level", int'(level), m_level);
      check("model_fault", int'(fault), m_fault);
      check("model_state", int'(state), e_state);
      check("model_mute",  int'(mute),  e_mute);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse(input logic a, input logic t);
    ack_pulse = a; test_pulse = t;
    @(negedge clk);
    ack_pulse = 1'b0; test_pulse = 1'b0;
  endtask

  task automatic rise_to_three();
    probe = 6'b000111;
    cyc(6);
    check("s1_level_early", int'(level), 0);
    cyc(1);
    check("s1_level", int'(level), 3);
    check("s1_state_lag", int'(state), 0);
    cyc(1);
    check("s1_state", int'(state), 3);
    check("s1_mute", int'(mute), 0);
    check("s1_fault", int'(fault), 0);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b0;
    #1;
    check({tag, "_rst_state"}, int'(state), 0);
    check({tag, "_rst_level"}, int'(level), 0);
    check({tag, "_rst_mute"},  int'(mute),  0);
    check({tag, "_rst_fault"}, int'(fault), 0);
    probe = '0;
    cyc(2);
    rst = 1'b1;
    cyc(3);
  endtask

  initial begin : stim
    int n7;
    cyc(2);
    check("reset_state", int'(state), 0);
    check("reset_level", int'(level), 0);
    rst = 1'b1;
    cyc(3);

    rise_to_three();

    // Fall with a one-cycle glitch that restarts the hold window
    probe = 6'b000001; cyc(10);
    probe = 6'b000111; cyc(1);
    probe = 6'b000001; cyc(18);
    check("s2_hold", int'(level), 3);
    cyc(1);
    check("s2_fall", int'(level), 1);
    probe = 6'b001111; cyc(7);
    check("s2_rise", int'(level), 4);

    pulse(1'b1, 1'b0); cyc(1);
    check("s3_mute", int'(mute), 1);
    check("s3_state", int'(state), 4);
    probe = 6'b000011; cyc(25);
    check("s3_fall_muted", int'(mute), 1);
    probe = 6'b011111; cyc(7);
    check("s3_rise_level", int'(level), 5);
    check("s3_mute_lag", int'(mute), 1);
    cyc(1);
    check("s3_rearm", int'(mute), 0);
    probe = 6'b000000; cyc(25);

    pulse(1'b0, 1'b1);
    n7 = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (state == 3'd7) n7++;
    end
    check("s4_test_len", n7, T);
    check("s4_after", int'(state), 0);
    pulse(1'b0, 1'b1); cyc(3);
    probe = 6'b000001; cyc(10);
    check("s4_abort", int'(state), 1);
    probe = 6'b000011; cyc(10);
    pulse(1'b1, 1'b1); cyc(3);
    check("s4_both_state", int'(state), 2);
    check("s4_both_mute", int'(mute), 1);
    probe = 6'b000000; cyc(25);

    probe = 6'b000101; cyc(7);
    check("s5_fault", int'(fault), 1);
    cyc(1);
    check("s5_state", int'(state), 6);
    check("s5_mute0", int'(mute), 0);
    pulse(1'b1, 1'b0); cyc(1);
    check("s5_ack", int'(mute), 1);
    probe = 6'b000011; cyc(7);
    check("s5_clear", int'(fault), 0);
    check("s5_level", int'(level), 2);
    cyc(1);
    check("s5_normal", int'(state), 2);
    check("s5_unmute", int'(mute), 0);

    probe = 6'b000000; cyc(25);
    pulse(1'b0, 1'b1); cyc(5);
    check("s6_in_test", int'(state), 7);
    async_reset_check("s6_test");
    rise_to_three();
    probe = 6'b011011; cyc(10);
    check("s6_in_fault", int'(state), 6);
    async_reset_check("s6_fault");
    rise_to_three();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
